// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command front end issuing one APB3 transfer at a time with wait-state timeout
module apb_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic abort;
  assign abort = (TIMEOUT != 0) && (wait_cnt == LAST);
  // Transfer sequencer: all handshake and APB outputs are registered alongside the state
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          PWRITE    <= cmd_write;
          PADDR     <= cmd_addr;
          PWDATA    <= cmd_wdata;
          PSEL      <= 1'b1;
          cmd_ready <= 1'b0;
          state     <= SETUP;
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: if (PREADY) begin
          rsp_rdata   <= PWRITE ? '0 : PRDATA;
          rsp_err     <= PSLVERR;
          rsp_timeout <= 1'b0;
          rsp_valid   <= 1'b1;
          PSEL        <= 1'b0;
          PENABLE     <= 1'b0;
          state       <= RESP;
        end else if (abort) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
          rsp_valid   <= 1'b1;
          PSEL        <= 1'b0;
          PENABLE     <= 1'b0;
          state       <= RESP;
        end else if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven scoreboard bench with a configurable APB slave model
module tb_apb_cmd_master;
  localparam int TO = 4;
  logic       sys_clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  int         s_wait = 0;
  logic [7:0] s_rdata = '0;
  logic       s_err = 1'b0;
  logic       s_stuck = 1'b0;
  int         wcnt = 0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] sdata;
    logic       serr;
    logic       stuck;
    int         hold;
    logic [7:0] e_rdata;
    logic       e_err;
    logic       e_to;
    int         e_lat;
  } vec_t;
  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         lat;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[9];
  apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 sys_clk = ~sys_clk;
  assign PREADY  = PSEL && PENABLE && !s_stuck && (wcnt == s_wait);
  assign PRDATA  = s_rdata;
  assign PSLVERR = s_err && PREADY;
  // Slave model: counts ACCESS wait cycles and records completed writes
  always @(posedge sys_clk) begin
    wcnt <= (PSEL && PENABLE && !PREADY) ? wcnt + 1 : 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      wr_addr <= PADDR;
      wr_data <= PWDATA;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic run(input vec_t v);
    int   cyc;
    bit   got;
    exp_t e;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk("cmd_ready_idle", cmd_ready, 1);
    s_wait    = v.waits;
    s_rdata   = v.sdata;
    s_err     = v.serr;
    s_stuck   = v.stuck;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    sb.push_back('{v.e_rdata, v.e_err, v.e_to, v.e_lat});
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    got = 0;
    while (!got && cyc < 20) begin
      if (rsp_valid) got = 1;
      else begin
        if (cyc >= 2) begin
          chk("access_psel", PSEL, 1);
          chk("access_penable", PENABLE, 1);
        end
        chk("paddr_stable", PADDR, v.addr);
        chk("pwrite_stable", PWRITE, v.wr);
        if (v.wr) chk("pwdata_stable", PWDATA, v.wdata);
        tick();
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", cyc);
      sys_reset = 1'b1;
      tick();
      sys_reset = 1'b0;
      return;
    end
    chk("rsp_latency", cyc, e.lat);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    chk("rsp_timeout", rsp_timeout, e.to);
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_cmd_ready", cmd_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'hEE;
      tick();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, e.rdata);
      chk("hold_rsp_err", rsp_err, e.err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", PSEL, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_psel", PSEL, 0);
    if (v.wr && !v.stuck) begin
      chk("slave_wr_addr", wr_addr, v.addr);
      chk("slave_wr_data", wr_data, v.wdata);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b1, 8'h00, 8'hA5, 0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 8'h01, 8'h00, 3, 8'h3C, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b0, 8'h7F, 8'h00, 0, 8'hEE, 1'b1, 1'b0, 2, 8'hEE, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 8'h02, 8'h00, 0, 8'h77, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b1, 2 + TO};
    vecs[4] = '{1'b0, 8'h03, 8'h00, 0, 8'h5A, 1'b0, 1'b0, 5, 8'h5A, 1'b0, 1'b0, 3};
    vecs[5] = '{1'b1, 8'h10, 8'h5C, 2, 8'h33, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 5};
    vecs[6] = '{1'b0, 8'h20, 8'h00, 1, 8'h81, 1'b0, 1'b0, 0, 8'h81, 1'b0, 1'b0, 4};
    vecs[7] = '{1'b1, 8'h30, 8'h99, 0, 8'h44, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b1, 2 + TO};
    vecs[8] = '{1'b1, 8'h40, 8'h0F, 3, 8'h55, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 6};
    tick();
    tick();
    sys_reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    for (int i = 0; i < 9; i++) run(vecs[i]);
    s_wait    = 3;
    s_rdata   = 8'h66;
    s_err     = 1'b0;
    s_stuck   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h05;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_access_penable", PENABLE, 1);
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_paddr", PADDR, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 0);
      chk("midrst_idle_psel", PSEL, 0);
    end
    run('{1'b1, 8'h06, 8'hC3, 1, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 4});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
